// File: rtl/zxtres_sram_arbiter_pkg.sv
// zxtres_sram_arbiter_pkg: FSM state encodings and requester port ids shared by the SRAM arbiter files
package zxtres_sram_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_FINISH} state_e;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
endpackage

// File: rtl/zxtres_sram_arbiter_rr_arb2.sv
// zxtres_sram_arbiter_rr_arb2: 2-way arbiter (req_a/req_b, mode 0=A fixed 1=round-robin, update) -> grant, preference flips on each grant
module zxtres_sram_arbiter_rr_arb2
  import zxtres_sram_arbiter_pkg::*;
(
  input  logic sysclk,
  input  logic reset_n,
  input  logic req_a,
  input  logic req_b,
  input  logic mode,
  input  logic update,
  output logic grant
);
  logic pref_q, pref_d;
  always_comb begin
    grant = (req_a && req_b) ? (mode ? pref_q : PORT_A) : (req_b ? PORT_B : PORT_A);
    pref_d = (update && (req_a || req_b)) ? ~grant : pref_q;
  end
  always_ff @(posedge sysclk or negedge reset_n)
    if (!reset_n) pref_q <= PORT_A;
    else pref_q <= pref_d;
endmodule

// File: rtl/zxtres_sram_arbiter.sv
// zxtres_sram_arbiter: shares a 1Mx16 SRAM between byte ports A/B via SETUP/STROBE/FINISH sequencing, addr[20] selects byte lane
module zxtres_sram_arbiter
  import zxtres_sram_arbiter_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int ARB_MODE = 1
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [20:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic [7:0]  a_rdata,
  output logic        a_ack,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [20:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic [7:0]  b_rdata,
  output logic        b_ack,
  output logic [19:0] sram_addr,
  output logic [15:0] sram_dout,
  input  logic [15:0] sram_din,
  output logic        sram_dout_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);
  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic gnt_q, gnt_d, we_q, we_d, hi_q, hi_d;
  logic [19:0] sram_addr_q, sram_addr_d;
  logic [15:0] sram_dout_q, sram_dout_d;
  logic dout_oe_q, dout_oe_d, we_n_q, we_n_d, oe_n_q, oe_n_d, ub_n_q, ub_n_d, lb_n_q, lb_n_d;
  logic a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [7:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic gnt;
  logic [20:0] g_addr;
  logic [7:0] g_wdata, lane;
  logic g_we;
  zxtres_sram_arbiter_rr_arb2 u_arb (
    .sysclk (sysclk),
    .reset_n(reset_n),
    .req_a  (a_req),
    .req_b  (b_req),
    .mode   (ARB_MODE != 0),
    .update (state_q == ST_IDLE),
    .grant  (gnt)
  );
  always_comb begin
    g_addr = gnt ? b_addr : a_addr;
    g_wdata = gnt ? b_wdata : a_wdata;
    g_we = gnt ? b_we : a_we;
    lane = hi_q ? sram_din[15:8] : sram_din[7:0];
    state_d = state_q;
    cnt_d = cnt_q;
    gnt_d = gnt_q;
    we_d = we_q;
    hi_d = hi_q;
    sram_addr_d = sram_addr_q;
    sram_dout_d = sram_dout_q;
    dout_oe_d = dout_oe_q;
    we_n_d = we_n_q;
    oe_n_d = oe_n_q;
    ub_n_d = ub_n_q;
    lb_n_d = lb_n_q;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      ST_IDLE: if (a_req || b_req) begin
        state_d = ST_SETUP;
        gnt_d = gnt;
        we_d = g_we;
        hi_d = g_addr[20];
        sram_addr_d = g_addr[19:0];
        sram_dout_d = {g_wdata, g_wdata};
        lb_n_d = g_addr[20];
        ub_n_d = ~g_addr[20];
        oe_n_d = g_we;
        dout_oe_d = g_we;
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d = 3'(WAIT_STATES - 1);
        we_n_d = ~we_q;
      end
      ST_STROBE: if (cnt_q == 3'd0) begin
        state_d = ST_FINISH;
        we_n_d = 1'b1;
        a_ack_d = gnt_q == PORT_A;
        b_ack_d = gnt_q == PORT_B;
        a_rdata_d = (!we_q && gnt_q == PORT_A) ? lane : a_rdata_q;
        b_rdata_d = (!we_q && gnt_q == PORT_B) ? lane : b_rdata_q;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        oe_n_d = 1'b1;
        dout_oe_d = 1'b0;
        ub_n_d = 1'b1;
        lb_n_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge sysclk or negedge reset_n)
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q <= 3'd0;
      gnt_q <= PORT_A;
      we_q <= 1'b0;
      hi_q <= 1'b0;
      sram_addr_q <= 20'd0;
      sram_dout_q <= 16'd0;
      dout_oe_q <= 1'b0;
      we_n_q <= 1'b1;
      oe_n_q <= 1'b1;
      ub_n_q <= 1'b1;
      lb_n_q <= 1'b1;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      a_rdata_q <= 8'd0;
      b_rdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      we_q <= we_d;
      hi_q <= hi_d;
      sram_addr_q <= sram_addr_d;
      sram_dout_q <= sram_dout_d;
      dout_oe_q <= dout_oe_d;
      we_n_q <= we_n_d;
      oe_n_q <= oe_n_d;
      ub_n_q <= ub_n_d;
      lb_n_q <= lb_n_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  assign sram_addr = sram_addr_q;
  assign sram_dout = sram_dout_q;
  assign sram_dout_oe = dout_oe_q;
  assign sram_we_n = we_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_ub_n = ub_n_q;
  assign sram_lb_n = lb_n_q;
  assign a_ack = a_ack_q;
  assign b_ack = b_ack_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
endmodule

// File: tb/tb_zxtres_sram_arbiter.sv
// tb_zxtres_sram_arbiter: checks two arbiter instances (WS=1 round-robin, WS=3 fixed) against SRAM device and byte-array reference models
module tb_zxtres_sram_arbiter;
  logic sysclk = 1'b0;
  logic reset_n = 1'b1;
  always #5 sysclk = ~sysclk;
  logic a_req [2], a_we [2], b_req [2], b_we [2], a_ack [2], b_ack [2];
  logic [20:0] a_addr [2], b_addr [2];
  logic [7:0] a_wdata [2], b_wdata [2], a_rdata [2], b_rdata [2];
  logic [19:0] sram_addr [2];
  logic [15:0] sram_dout [2];
  logic sram_dout_oe [2], sram_we_n [2], sram_oe_n [2], sram_ub_n [2], sram_lb_n [2];
  int vectors = 0;
  int miscompares = 0;
  int lat, we_lo, doe, oth;
  logic [19:0] s_addr;
  logic s_ub, s_lb, s_oe, s_we;
  logic [15:0] s_dout;
  logic [7:0] rd;
  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [15:0] din = 16'hFFFF;
    logic [15:0] w;
    logic [15:0] dev [logic [19:0]];
    zxtres_sram_arbiter #(.WAIT_STATES(g == 0 ? 1 : 3), .ARB_MODE(g == 0 ? 1 : 0)) u_dut (
      .sysclk      (sysclk),
      .reset_n     (reset_n),
      .a_req       (a_req[g]),
      .a_we        (a_we[g]),
      .a_addr      (a_addr[g]),
      .a_wdata     (a_wdata[g]),
      .a_rdata     (a_rdata[g]),
      .a_ack       (a_ack[g]),
      .b_req       (b_req[g]),
      .b_we        (b_we[g]),
      .b_addr      (b_addr[g]),
      .b_wdata     (b_wdata[g]),
      .b_rdata     (b_rdata[g]),
      .b_ack       (b_ack[g]),
      .sram_addr   (sram_addr[g]),
      .sram_dout   (sram_dout[g]),
      .sram_din    (din),
      .sram_dout_oe(sram_dout_oe[g]),
      .sram_we_n   (sram_we_n[g]),
      .sram_oe_n   (sram_oe_n[g]),
      .sram_ub_n   (sram_ub_n[g]),
      .sram_lb_n   (sram_lb_n[g])
    );
    always @(negedge sysclk) begin
      w = dev.exists(sram_addr[g]) ? dev[sram_addr[g]] : 16'h0;
      if (!sram_we_n[g]) begin
        if (!sram_lb_n[g]) w[7:0] = sram_dout[g][7:0];
        if (!sram_ub_n[g]) w[15:8] = sram_dout[g][15:8];
        dev[sram_addr[g]] = w;
      end
      din = !sram_oe_n[g] ? w : 16'hFFFF;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drv(input int g, input bit p, input logic req, input logic we, input logic [20:0] ad, input logic [7:0] wd);
    if (p) begin
      b_req[g] = req; b_we[g] = we; b_addr[g] = ad; b_wdata[g] = wd;
    end else begin
      a_req[g] = req; a_we[g] = we; a_addr[g] = ad; a_wdata[g] = wd;
    end
  endtask
  task automatic acc(input int g, input bit p, input logic we, input logic [20:0] ad, input logic [7:0] wd, input int drop);
    int c = 0;
    drv(g, p, 1'b1, we, ad, wd);
    lat = -1; we_lo = 0; doe = 0; oth = 0; rd = 8'hxx;
    while (lat < 0 && c < 30) begin
      @(negedge sysclk); #1;
      c++;
      if (c == drop) drv(g, p, 1'b0, we, ~ad, ~wd);
      if (c == 1) begin
        s_addr = sram_addr[g]; s_ub = sram_ub_n[g]; s_lb = sram_lb_n[g];
        s_oe = sram_oe_n[g]; s_we = sram_we_n[g]; s_dout = sram_dout[g];
      end
      if (!sram_we_n[g]) we_lo++;
      if (sram_dout_oe[g]) doe++;
      if (p ? a_ack[g] : b_ack[g]) oth++;
      if (p ? b_ack[g] : a_ack[g]) begin
        lat = c;
        rd = p ? b_rdata[g] : a_rdata[g];
      end
    end
    drv(g, p, 1'b0, 1'b0, 21'h0, 8'h0);
    @(negedge sysclk); #1;
  endtask
  initial begin
    int q0 [$];
    int q1 [$];
    int nak, acks, viol, spur;
    bit pend [2];
    logic pwe [2];
    logic [20:0] pad [2];
    logic [7:0] pwd [2];
    logic [7:0] ref_mem [int];
    logic ak;
    for (int g = 0; g < 2; g++) begin
      drv(g, 1'b0, 1'b0, 1'b0, 21'h0, 8'h0);
      drv(g, 1'b1, 1'b0, 1'b0, 21'h0, 8'h0);
    end
    #1 reset_n = 1'b0;
    repeat (3) @(negedge sysclk);
    #1;
    chk("rst_we_n", sram_we_n[0], 1);
    chk("rst_oe_n", sram_oe_n[0], 1);
    chk("rst_ub_n", sram_ub_n[0], 1);
    chk("rst_lb_n", sram_lb_n[0], 1);
    chk("rst_dout_oe", sram_dout_oe[0], 0);
    chk("rst_addr", sram_addr[0], 0);
    chk("rst_dout", sram_dout[0], 0);
    chk("rst_acks", {a_ack[0], b_ack[0], a_ack[1], b_ack[1]}, 0);
    chk("rst_rdata", {a_rdata[0], b_rdata[0]}, 0);
    reset_n = 1'b1;
    @(negedge sysclk); #1;
    acc(0, 1'b0, 1'b1, 21'h000123, 8'h5A, 0);
    chk("a_wr_lat", lat, 3);
    chk("a_wr_we_lo", we_lo, 1);
    chk("a_wr_lanes", {s_ub, s_lb}, 2'b10);
    acc(0, 1'b0, 1'b1, 21'h100123, 8'hAB, 0);
    acc(0, 1'b0, 1'b0, 21'h000123, 8'h00, 0);
    chk("a_rd_addr", s_addr, 20'h00123);
    chk("a_rd_lanes", {s_ub, s_lb}, 2'b10);
    chk("a_rd_oe_n", s_oe, 0);
    chk("a_rd_lat", lat, 3);
    chk("a_rd_data", rd, 8'h5A);
    chk("a_rd_doe", doe, 0);
    chk("a_rd_b_ack", oth, 0);
    acc(0, 1'b1, 1'b1, 21'h100123, 8'hC3, 0);
    chk("b_wr_lanes", {s_ub, s_lb}, 2'b01);
    chk("b_wr_dout", s_dout, 16'hC3C3);
    chk("b_wr_setup_we_n", s_we, 1);
    chk("b_wr_setup_oe_n", s_oe, 1);
    chk("b_wr_we_lo", we_lo, 1);
    chk("b_wr_doe", doe, 3);
    chk("b_wr_lat", lat, 3);
    chk("b_wr_a_ack", oth, 0);
    acc(0, 1'b1, 1'b0, 21'h100123, 8'h00, 0);
    chk("b_rd_data", rd, 8'hC3);
    acc(0, 1'b0, 1'b0, 21'h000123, 8'h00, 0);
    chk("a_rd_lane_iso", rd, 8'h5A);
    acc(1, 1'b0, 1'b1, 21'h000200, 8'h77, 1);
    chk("ws3_wr_lat", lat, 5);
    chk("ws3_wr_we_lo", we_lo, 3);
    chk("ws3_wr_doe", doe, 5);
    acc(1, 1'b1, 1'b0, 21'h000200, 8'h00, 0);
    chk("ws3_rd_lat", lat, 5);
    chk("ws3_rd_data", rd, 8'h77);
    drv(1, 1'b0, 1'b1, 1'b1, 21'h100300, 8'h99);
    repeat (2) @(negedge sysclk);
    #1;
    chk("pre_rst_we_n", sram_we_n[1], 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_we_n", sram_we_n[1], 1);
    chk("mid_rst_doe", sram_dout_oe[1], 0);
    chk("mid_rst_lanes", {sram_ub_n[1], sram_lb_n[1]}, 2'b11);
    drv(1, 1'b0, 1'b0, 1'b0, 21'h0, 8'h0);
    @(negedge sysclk); #1;
    reset_n = 1'b1;
    nak = 0;
    repeat (10) begin
      @(negedge sysclk); #1;
      nak += int'(a_ack[1]) + int'(b_ack[1]);
    end
    chk("post_rst_ack", nak, 0);
    for (int g = 0; g < 2; g++) begin
      drv(g, 1'b0, 1'b1, 1'b0, 21'h000010, 8'h0);
      drv(g, 1'b1, 1'b1, 1'b0, 21'h100010, 8'h0);
    end
    for (int c = 0; c < 300 && (q0.size() < 6 || q1.size() < 6); c++) begin
      @(negedge sysclk); #1;
      if (a_ack[0]) q0.push_back(0);
      if (b_ack[0]) q0.push_back(1);
      if (a_ack[1]) q1.push_back(0);
      if (b_ack[1]) q1.push_back(1);
    end
    for (int g = 0; g < 2; g++) begin
      drv(g, 1'b0, 1'b0, 1'b0, 21'h0, 8'h0);
      drv(g, 1'b1, 1'b0, 1'b0, 21'h0, 8'h0);
    end
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr_order_%0d", k), k < q0.size() ? q0[k] : -1, k % 2);
      chk($sformatf("fixed_order_%0d", k), k < q1.size() ? q1[k] : -1, 0);
    end
    repeat (10) @(negedge sysclk);
    #1;
    acks = 0; viol = 0; spur = 0;
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 60000 && acks < 10000; c++) begin
      @(negedge sysclk); #1;
      if (!sram_oe_n[0] && sram_dout_oe[0]) viol++;
      for (int p = 0; p < 2; p++) begin
        ak = p ? b_ack[0] : a_ack[0];
        if (ak) begin
          if (!pend[p]) spur++;
          else begin
            if (pwe[p]) ref_mem[int'(pad[p])] = pwd[p];
            else chk("rnd_rd", p ? b_rdata[0] : a_rdata[0], ref_mem.exists(int'(pad[p])) ? ref_mem[int'(pad[p])] : 8'h0);
            acks++;
          end
          pend[p] = 0;
          drv(0, bit'(p), 1'b0, 1'b0, 21'h0, 8'h0);
        end else if (!pend[p] && $urandom_range(7) != 0) begin
          pend[p] = 1;
          pwe[p] = 1'($urandom);
          pad[p] = {1'($urandom), 16'h4000, 4'($urandom)};
          pwd[p] = 8'($urandom);
          drv(0, bit'(p), 1'b1, pwe[p], pad[p], pwd[p]);
        end
      end
    end
    chk("rnd_acks", acks, 10000);
    chk("rnd_bus_inv", viol, 0);
    chk("rnd_spur_ack", spur, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
